iddmm_res_pack: RTL and testbench

Result packer directly downstream of the IDDMM controller. Captures the word-serial Montgomery result (K-bit words, LSW first, qualified by `task_grant`, last word marked by `task_end`) into one of two N×K banks and presents the full N·K-bit product through a valid/ready handshake. Ping-pong banking lets the multiplier stream the next result while the consumer (the modexp/Paillier sequencer) still holds the previous one. `slot_free` lets the consumer gate the next `task_req`.

---
 rtl/iddmm_pkg.sv | 32 +++
 rtl/iddmm_res_bank.sv | 42 ++++
 rtl/iddmm_res_pack.sv | 178 +++++++++++++++++
 tb/tb_iddmm_res_pack.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_pkg
// Description : Shared defaults and types for the IDDMM controller and its
//               result packer: word width, words per result, word-index and
//               bank-index types, and the packer's write-side state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package iddmm_pkg;

    localparam int K_DEFAULT      = 256;
    localparam int N_DEFAULT      = 16;
    localparam int ADDR_W_DEFAULT = $clog2(N_DEFAULT);

    // Word index within a result at the default geometry.
    typedef logic [ADDR_W_DEFAULT-1:0] word_idx_t;

    // One of the two ping-pong banks.
    typedef logic bank_idx_t;

    // Write side either fills a bank or swallows the rest of a bad frame.
    typedef enum logic [0:0] {
        WR_FILL = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    function automatic bank_idx_t other_bank(input bank_idx_t b);
        return ~b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iddmm_res_bank.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_res_bank
// Description : N x K register array holding one packed Montgomery result.
//               Indexed single-word write, full-width read, async clear.
// Ports       : clk, rst_n      - clock, async active-low clear
//               we, waddr, wdata - word write strobe, index and data
//               rdata            - all N words, word i at [i*K +: K]
// Revision    : 1.0 - initial release
// ============================================================================
module iddmm_res_bank #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [K-1:0]      wdata,
    output logic [N*K-1:0]    rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            logic [K-1:0] word_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    word_q <= wdata;
                end
            end

            assign rdata[gi*K +: K] = word_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/iddmm_res_pack.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_res_pack
// Description : Packs the word-serial IDDMM result (LSW first) into one of two
//               ping-pong banks and presents the full N*K-bit product through
//               a valid/ready handshake.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               task_grant, task_end, task_res - word stream from controller
//               res_valid, res_ready, res_data - packed result handshake
//               slot_free                      - write bank can take a frame
//               frame_err                      - 1-cycle malformed-frame pulse
//               ovf, ovf_clr                   - sticky overflow and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module iddmm_res_pack
    import iddmm_pkg::*;
#(
    parameter int K      = K_DEFAULT,
    parameter int N      = N_DEFAULT,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           task_grant,
    input  logic           task_end,
    input  logic [K-1:0]   task_res,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*K-1:0] res_data,
    output logic           slot_free,
    output logic           frame_err,
    output logic           ovf,
    input  logic           ovf_clr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_e         wr_state, wr_state_nxt;
    bank_idx_t         wr_bank, wr_bank_nxt;
    bank_idx_t         rd_bank, rd_bank_nxt;
    logic [1:0]        bank_full, bank_full_nxt;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;
    logic              frame_err_nxt;
    logic              ovf_nxt;

    // Datapath / decode
    logic              word_we;
    logic              ovf_set;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              pop;
    logic [1:0]        bank_we;
    logic [N*K-1:0]    bank_rdata [2];

    assign pop       = res_valid & res_ready;
    assign res_valid = bank_full[rd_bank];
    assign res_data  = bank_rdata[rd_bank];
    assign slot_free = ~bank_full[wr_bank];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= WR_FILL;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            wr_bank   <= wr_bank_nxt;
            rd_bank   <= rd_bank_nxt;
            bank_full <= bank_full_nxt;
            wr_cnt    <= wr_cnt_nxt;
            frame_err <= frame_err_nxt;
            ovf       <= ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write side: word accept, frame completion, error and overflow.
    // A full write bank always has wr_cnt == 0 (completion resets it),
    // so a grant against a full bank is necessarily an overflow.
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_nxt  = wr_state;
        wr_bank_nxt   = wr_bank;
        wr_cnt_nxt    = wr_cnt;
        frame_err_nxt = 1'b0;
        ovf_set       = 1'b0;
        word_we       = 1'b0;
        full_set      = 2'b00;

        if (task_grant) begin
            if (wr_state == WR_DROP) begin
                if (task_end) begin
                    wr_state_nxt = WR_FILL;
                    wr_cnt_nxt   = '0;
                end
            end else if (bank_full[wr_bank]) begin
                ovf_set    = 1'b1;
                wr_cnt_nxt = '0;
                // A single-word frame carrying task_end is dropped whole here.
                if (!task_end) begin
                    wr_state_nxt = WR_DROP;
                end
            end else begin
                word_we = 1'b1;
                if (task_end && (wr_cnt == LAST_IDX)) begin
                    full_set[wr_bank] = 1'b1;
                    wr_bank_nxt       = other_bank(wr_bank);
                    wr_cnt_nxt        = '0;
                end else if (!task_end && (wr_cnt != LAST_IDX)) begin
                    wr_cnt_nxt = wr_cnt + 1'b1;
                end else begin
                    // Partial words stay in the bank but it is never marked
                    // full, so the next frame simply overwrites them.
                    frame_err_nxt = 1'b1;
                    wr_cnt_nxt    = '0;
                    if (!task_end) begin
                        wr_state_nxt = WR_DROP;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side and shared flags. Completion and pop never target the
    // same bank in one cycle, so set/clear masks can be merged freely.
    // ------------------------------------------------------------------
    always_comb begin
        full_clr    = 2'b00;
        rd_bank_nxt = rd_bank;
        if (pop) begin
            full_clr[rd_bank] = 1'b1;
            rd_bank_nxt       = other_bank(rd_bank);
        end
        bank_full_nxt = (bank_full | full_set) & ~full_clr;

        // New overflow takes priority over a simultaneous clear.
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong banks
    // ------------------------------------------------------------------
    genvar gb;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bank
            assign bank_we[gb] = word_we && (wr_bank == bank_idx_t'(gb));

            iddmm_res_bank #(
                .K      (K),
                .N      (N),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk    (clk),
                .rst_n  (rst_n),
                .we     (bank_we[gb]),
                .waddr  (wr_cnt),
                .wdata  (task_res),
                .rdata  (bank_rdata[gb])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_iddmm_res_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_iddmm_res_pack
// Description : Scoreboard bench for iddmm_res_pack (K=8, N=4). A frame-level
//               model (held-result count, partial-word queue, drop flag)
//               predicts status flags and the order of packed results; a
//               monitor compares the DUT on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iddmm_res_pack;

    localparam int K      = 8;
    localparam int N      = 4;
    localparam int ADDR_W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           task_grant = 1'b0;
    logic           task_end = 1'b0;
    logic [K-1:0]   task_res = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [N*K-1:0] res_data;
    logic           slot_free;
    logic           frame_err;
    logic           ovf;
    logic           ovf_clr = 1'b0;

    always #5 clk = ~clk;

    iddmm_res_pack #(
        .K      (K),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .task_grant (task_grant),
        .task_end   (task_end),
        .task_res   (task_res),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .slot_free  (slot_free),
        .frame_err  (frame_err),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard of completed results, oldest first.
    logic [N*K-1:0] sb_q[$];

    // Behavioural model
    int           held      = 0;   // results waiting for the consumer
    bit           dropping  = 1'b0;
    logic [K-1:0] part[$];         // words of the frame in progress
    bit           m_ovf     = 1'b0;

    // Published expectations for the monitor
    bit exp_valid     = 1'b0;
    bit exp_slot_free = 1'b1;
    bit exp_ferr      = 1'b0;
    bit exp_ovf       = 1'b0;
    bit exp_zero      = 1'b1;
    bit mon_en        = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input bit g, input bit e, input logic [K-1:0] d,
                              input bit r, input bit c);
        bit             pop;
        bit             comp;
        bit             ferr;
        bit             oset;
        logic [N*K-1:0] f;
        pop  = r && (held > 0);
        comp = 1'b0;
        ferr = 1'b0;
        oset = 1'b0;
        if (g) begin
            exp_zero = 1'b0;
            if (dropping) begin
                if (e) dropping = 1'b0;
            end else if (part.size() == 0 && held == 2) begin
                oset = 1'b1;
                if (!e) dropping = 1'b1;
            end else begin
                part.push_back(d);
                if (e && part.size() == N) begin
                    f = '0;
                    for (int i = 0; i < N; i++) f[i*K +: K] = part[i];
                    sb_q.push_back(f);
                    comp = 1'b1;
                    part.delete();
                end else if (e || part.size() == N) begin
                    ferr = 1'b1;
                    part.delete();
                    if (!e) dropping = 1'b1;
                end
            end
        end
        held = held - (pop ? 1 : 0) + (comp ? 1 : 0);
        if (oset)   m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        exp_valid     = (held > 0);
        exp_slot_free = (held < 2);
        exp_ferr      = ferr;
        exp_ovf       = m_ovf;
    endtask

    // Drive inputs a little after a rising edge; model the next edge.
    task automatic step(input bit g, input bit e, input logic [K-1:0] d,
                        input bit r, input bit c);
        task_grant = g;
        task_end   = e;
        task_res   = d;
        res_ready  = r;
        ovf_clr    = c;
        @(posedge clk);
        model_edge(g, e, d, r, c);
        #2;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r, 1'b0);
    endtask

    task automatic frame(input logic [N*K-1:0] f, input bit r);
        for (int i = 0; i < N; i++) step(1'b1, (i == N-1), f[i*K +: K], r, 1'b0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        task_grant = 1'b0;
        task_end   = 1'b0;
        task_res   = '0;
        res_ready  = 1'b0;
        ovf_clr    = 1'b0;
        held       = 0;
        dropping   = 1'b0;
        m_ovf      = 1'b0;
        part.delete();
        sb_q.delete();
        exp_valid     = 1'b0;
        exp_slot_free = 1'b1;
        exp_ferr      = 1'b0;
        exp_ovf       = 1'b0;
        exp_zero      = 1'b1;
        mon_en        = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: status every falling edge, data on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check("res_valid", {63'd0, res_valid}, {63'd0, exp_valid});
            check("slot_free", {63'd0, slot_free}, {63'd0, exp_slot_free});
            check("frame_err", {63'd0, frame_err}, {63'd0, exp_ferr});
            check("ovf",       {63'd0, ovf},       {63'd0, exp_ovf});
            if (exp_zero) check("res_data_reset", {32'd0, res_data}, 64'd0);
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got data %0h expected no result", res_data);
                end else begin
                    check("res_data", {32'd0, res_data}, {32'd0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        bit g, e, r, c;
        int wc;

        do_reset();

        // Single frame, consumer ready.
        frame(32'h44332211, 1'b1);
        idle(3, 1'b1);

        // Two frames held, then drained in order.
        frame(32'hA4A3A2A1, 1'b0);
        frame(32'hB4B3B2B1, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Third frame overflows; held results survive; clear ovf.
        frame(32'h0D0C0B0A, 1'b0);
        frame(32'h1D1C1B1A, 1'b0);
        frame(32'hEEEEEEEE, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Early task_end on word 3, then a good frame.
        step(1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
        idle(2, 1'b1);
        frame(32'hA4A3A2A1, 1'b1);
        idle(2, 1'b1);

        // Five-word frame: error on word 4, word 5 swallowed.
        for (int i = 0; i < 5; i++) step(1'b1, (i == 4), 8'(8'h50 + i), 1'b1, 1'b0);
        idle(2, 1'b1);
        frame(32'h64636261, 1'b1);
        idle(2, 1'b1);

        // Reset after two words, then a clean frame from index 0.
        step(1'b1, 1'b0, 8'h71, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h72, 1'b0, 1'b0);
        do_reset();
        idle(1, 1'b0);
        frame(32'h84838281, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic.
        wc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            g = ($urandom_range(0, 3) != 0);
            e = 1'b0;
            if (g) begin
                if (wc == N-1)  e = ($urandom_range(0, 15) != 0);
                else if (wc >= N+1) e = 1'b1;
                else            e = ($urandom_range(0, 19) == 0);
                wc = e ? 0 : wc + 1;
            end
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(g, e, 8'($urandom_range(0, 255)), r, c);
        end

        // Drain and confirm nothing predicted was left unseen.
        idle(6, 1'b1);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
